text_ram_arbiter: RTL and testbench

TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

---
 rtl/text_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_text_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: one synchronous single-port RAM shared by video reads, a clear engine and a host port.
// Defining TEXT_RAM_ARB_STATS_EN adds the saturating host stall counter output host_stall_cnt_o.
module text_ram_arbiter #(
   parameter int                    ADDR_WIDTH     = 12,
   parameter int                    DATA_WIDTH     = 16,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = 16'h0020,
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] vid_addr_i,
   input  logic                  vid_rd_strobe_i,
   output logic [DATA_WIDTH-1:0] vid_data_o,
   input  logic                  host_req_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_wdata_i,
   output logic                  host_gnt_o,
   output logic                  host_rvalid_o,
   output logic [DATA_WIDTH-1:0] host_rdata_o,
   input  logic                  clear_i,
   output logic                  busy_o,
`ifdef TEXT_RAM_ARB_STATS_EN
   output logic [15:0]           host_stall_cnt_o,
`endif
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;
   logic                  r_clr_pend;
   logic                  w_host_gnt;
   logic                  w_clr_issue;
   logic                  r_vid_p1;
   logic                  r_vid_p2;
   logic                  r_host_p1;
   logic                  r_host_p2;
   logic                  r_host_rvalid;
   logic [DATA_WIDTH-1:0] r_vid_data;
   logic [DATA_WIDTH-1:0] r_host_rdata;
   logic                  r_mem_en;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   // Video always wins; the clear engine stalls behind it, the host waits for both.
   assign w_host_gnt  = host_req_i & ~vid_rd_strobe_i & (r_state == ST_IDLE) & ~clear_i;
   assign w_clr_issue = (r_state == ST_CLEAR) & ~vid_rd_strobe_i;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (clear_i || r_clr_pend) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            if (clear_i) begin
               w_cnt_nxt = '0;
            end else if (w_clr_issue) begin
               if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_clr_pend    <= CLEAR_ON_RESET;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_vid_p1      <= 1'b0;
         r_vid_p2      <= 1'b0;
         r_host_p1     <= 1'b0;
         r_host_p2     <= 1'b0;
         r_host_rvalid <= 1'b0;
         r_vid_data    <= '0;
         r_host_rdata  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_clr_pend <= 1'b0;
         r_mem_en   <= vid_rd_strobe_i | w_clr_issue | w_host_gnt;
         if (vid_rd_strobe_i) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= vid_addr_i;
         end else if (w_clr_issue) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt;
            r_mem_wdata <= FILL_VALUE;
         end else if (w_host_gnt) begin
            r_mem_we   <= host_we_i;
            r_mem_addr <= host_addr_i;
            if (host_we_i) r_mem_wdata <= host_wdata_i;
         end else begin
            r_mem_we <= 1'b0;
         end
         // Read tags follow the access through the RAM's one-cycle latency.
         r_vid_p1      <= vid_rd_strobe_i;
         r_vid_p2      <= r_vid_p1;
         r_host_p1     <= w_host_gnt & ~host_we_i;
         r_host_p2     <= r_host_p1;
         r_host_rvalid <= r_host_p2;
         if (r_vid_p2) r_vid_data <= mem_rdata_i;
         if (r_host_p2) r_host_rdata <= mem_rdata_i;
      end
   end

`ifdef TEXT_RAM_ARB_STATS_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (host_req_i && !w_host_gnt && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign host_stall_cnt_o = r_stall_cnt;
`else
   // Stall counter is absent from this build.
`endif

   assign vid_data_o    = r_vid_data;
   assign host_gnt_o    = w_host_gnt;
   assign host_rvalid_o = r_host_rvalid;
   assign host_rdata_o  = r_host_rdata;
   assign busy_o        = (r_state == ST_CLEAR);
   assign mem_en_o      = r_mem_en;
   assign mem_we_o      = r_mem_we;
   assign mem_addr_o    = r_mem_addr;
   assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter (ADDR_WIDTH=4): synchronous RAM model, shadow-memory reference with due-cycle queues.
// Stall-counter checks are included when TEXT_RAM_ARB_STATS_EN is defined.
module tb_text_ram_arbiter;
   localparam int          AW   = 4;
   localparam int          DW   = 16;
   localparam logic [15:0] FILL = 16'h0020;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] vid_addr_i = '0;
   logic          vid_rd_strobe_i = 1'b0;
   logic [DW-1:0] vid_data_o;
   logic          host_req_i = 1'b0;
   logic          host_we_i = 1'b0;
   logic [AW-1:0] host_addr_i = '0;
   logic [DW-1:0] host_wdata_i = '0;
   logic          host_gnt_o;
   logic          host_rvalid_o;
   logic [DW-1:0] host_rdata_o;
   logic          clear_i = 1'b0;
   logic          busy_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
`ifdef TEXT_RAM_ARB_STATS_EN
   logic [15:0]   host_stall_cnt_o;
   logic [15:0]   stall0;
`endif

   text_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_VALUE(FILL), .CLEAR_ON_RESET(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .vid_addr_i(vid_addr_i), .vid_rd_strobe_i(vid_rd_strobe_i), .vid_data_o(vid_data_o),
      .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
      .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
      .host_rdata_o(host_rdata_o), .clear_i(clear_i), .busy_o(busy_o),
`ifdef TEXT_RAM_ARB_STATS_EN
      .host_stall_cnt_o(host_stall_cnt_o),
`endif
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM seen by the arbiter
   logic [DW-1:0] ram [16];
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
         else mem_rdata_i <= ram[mem_addr_o];
      end
   end

   // Reference model: expected RAM contents plus results due at given cycles
   logic [DW-1:0] shadow [16];
   int            vid_due_q[$];
   int            host_due_q[$];
   logic [DW-1:0] vid_exp_q[$];
   logic [DW-1:0] host_exp_q[$];
   logic [DW-1:0] hold_vid  = '0;
   logic [DW-1:0] hold_host = '0;
   bit            model_busy = 1'b0;
   int            n_cmp = 0;
   int            n_err = 0;

   int            c_busy_n;
   int            c_wr_n;
   logic [15:0]   c_mask;
   logic [AW-1:0] c_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      vid_due_q.delete();
      host_due_q.delete();
      vid_exp_q.delete();
      host_exp_q.delete();
      hold_vid  = '0;
      hold_host = '0;
   endtask

   task automatic check_outputs();
      logic exp_rv;
      exp_rv = (host_due_q.size() > 0) && (host_due_q[0] == cyc);
      chk("host_rvalid", host_rvalid_o, exp_rv);
      if (exp_rv) begin
         void'(host_due_q.pop_front());
         hold_host = host_exp_q.pop_front();
      end
      chk("host_rdata", host_rdata_o, hold_host);
      if ((vid_due_q.size() > 0) && (vid_due_q[0] == cyc)) begin
         void'(vid_due_q.pop_front());
         hold_vid = vid_exp_q.pop_front();
      end
      chk("vid_data", vid_data_o, hold_vid);
   endtask

   // Driver: apply one cycle of inputs, check grant, update model, advance to next negedge.
   task automatic step(input logic v, input logic [AW-1:0] va, input logic rq, input logic we,
                       input logic [AW-1:0] ha, input logic [DW-1:0] wd, input logic clr);
      logic exp_gnt;
      vid_rd_strobe_i = v;
      vid_addr_i      = va;
      host_req_i      = rq;
      host_we_i       = we;
      host_addr_i     = ha;
      host_wdata_i    = wd;
      clear_i         = clr;
      #1;
      exp_gnt = rq && !v && !model_busy && !clr;
      chk("host_gnt", host_gnt_o, exp_gnt);
      if (v) begin
         vid_due_q.push_back(cyc + 3);
         vid_exp_q.push_back(shadow[va]);
      end
      if (exp_gnt && !we) begin
         host_due_q.push_back(cyc + 3);
         host_exp_q.push_back(shadow[ha]);
      end
      if (exp_gnt && we) shadow[ha] = wd;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_step();
      step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic mon_clear();
      if (busy_o) c_busy_n++;
      if (mem_en_o && mem_we_o) begin
         chk("clr_wdata", mem_wdata_o, FILL);
         c_mask[mem_addr_o] = 1'b1;
         c_last = mem_addr_o;
         c_wr_n++;
      end
   endtask

   // Post-reset clear: busy the first cycle after release, ordered fill of 0..15, then idle.
   task automatic reset_clear_check();
      int  busy_n;
      int  wr_n;
      bit  done;
      busy_n = 0;
      wr_n   = 0;
      done   = 1'b0;
      idle_step();
      chk("rst_busy_first", busy_o, 1'b1);
      for (int k = 0; k < 60 && !done; k++) begin
         if (busy_o) busy_n++;
         if (mem_en_o && mem_we_o) begin
            chk("rst_clr_addr", mem_addr_o, wr_n);
            chk("rst_clr_wdata", mem_wdata_o, FILL);
            wr_n++;
         end
         if (!busy_o && busy_n > 0) done = 1'b1;
         else idle_step();
      end
      chk("rst_clr_done", done, 1'b1);
      chk("rst_clr_busy_cycles", busy_n, 16);
      chk("rst_clr_writes", wr_n, 16);
      for (int i = 0; i < 16; i++) shadow[i] = FILL;
   endtask

   initial begin
      logic [AW-1:0] va;
      logic [AW-1:0] ha;
      for (int i = 0; i < 16; i++) ram[i] = 16'hDEA0 ^ 16'(i * 37);

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_vid_data", vid_data_o, 16'h0);
      chk("rst_host_rdata", host_rdata_o, 16'h0);
      chk("rst_rvalid", host_rvalid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 4'h0);
      chk("rst_mem_wdata", mem_wdata_o, 16'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      reset_clear_check();

      // Write then read the same address on consecutive cycles
      step(1'b0, '0, 1'b1, 1'b1, 4'h5, 16'hABCD, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 4'h5, 16'h0, 1'b0);
      idle_step();
      idle_step();
      chk("r025_rvalid", host_rvalid_o, 1'b1);
      chk("r025_rdata", host_rdata_o, 16'hABCD);
      idle_step();
      chk("r025_rvalid_pulse", host_rvalid_o, 1'b0);

      // Random mixed traffic
      for (int k = 0; k < 150; k++) begin
         step($urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
      end
      repeat (3) idle_step();

      // Video and host read in the same cycle
      va = AW'($urandom_range(0, 15));
      ha = AW'($urandom_range(0, 15));
      step(1'b1, va, 1'b1, 1'b0, ha, '0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, ha, '0, 1'b0);
      idle_step();
      chk("r026_vid", vid_data_o, shadow[va]);
      idle_step();
      chk("r026_host_rvalid", host_rvalid_o, 1'b1);
      chk("r026_host_rdata", host_rdata_o, shadow[ha]);

      // Ten back-to-back video strobes with the host held off
      for (int k = 0; k < 10; k++) begin
         step(1'b1, AW'($urandom_range(0, 15)), 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, 1'b0);
      end
      repeat (3) idle_step();
      chk("r027_vid_drained", vid_due_q.size(), 0);

`ifdef TEXT_RAM_ARB_STATS_EN
      // Stall counter across a 5-cycle video burst
      stall0 = host_stall_cnt_o;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, AW'($urandom_range(0, 15)), 1'b1, 1'b0, 4'h3, '0, 1'b0);
      end
      chk("r029_stall", host_stall_cnt_o, stall0 + 16'd5);
      step(1'b0, '0, 1'b1, 1'b0, 4'h3, '0, 1'b0);
      chk("r029_stall_hold", host_stall_cnt_o, stall0 + 16'd5);
      repeat (3) idle_step();
`endif

      // Clear restarted at counter 7, host held off throughout
      c_busy_n = 0;
      c_wr_n   = 0;
      c_mask   = '0;
      c_last   = '0;
      step(1'b0, '0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, 1'b1);
      model_busy = 1'b1;
      mon_clear();
      for (int k = 1; k <= 24; k++) begin
         step(1'b0, '0, 1'b1, 1'b0, AW'($urandom_range(0, 15)), '0, k == 8);
         mon_clear();
      end
      model_busy = 1'b0;
      chk("r028_busy_end", busy_o, 1'b0);
      chk("r028_busy_cycles", c_busy_n, 24);
      chk("r028_writes", c_wr_n, 24);
      chk("r028_mask", c_mask, 16'hFFFF);
      chk("r028_last", c_last, 4'hF);
      for (int i = 0; i < 16; i++) shadow[i] = FILL;

      // Read back the cleared contents
      for (int k = 0; k < 20; k++) begin
         step($urandom_range(0, 1) == 0, AW'($urandom_range(0, 15)), 1'b1, 1'b0,
              AW'($urandom_range(0, 15)), '0, 1'b0);
      end
      repeat (3) idle_step();

      // Reset with reads in flight
      step(1'b0, '0, 1'b1, 1'b0, 4'h2, '0, 1'b0);
      step(1'b1, 4'h9, 1'b0, 1'b0, '0, '0, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", host_rvalid_o, 1'b0);
      chk("mid_rst_vid_data", vid_data_o, 16'h0);
      chk("mid_rst_mem_en", mem_en_o, 1'b0);
      chk("mid_rst_busy", busy_o, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      reset_clear_check();

      repeat (4) idle_step();
      chk("end_vid_q", vid_due_q.size(), 0);
      chk("end_host_q", host_due_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
